// File: rtl/checker_auto.sv
// checker_auto -- periodic MPU sequencer for the checker.
//
// Started through the shared mode bus. The block runs the MPU program over and
// over at a programmed period. The result of the first run becomes the
// baseline, and every later run is compared against that baseline. The block
// finishes with an IRQ on any of these events:
//   - a result mismatch
//   - an MPU error
//   - a watchdog timeout (optional)
//   - the programmed run count being reached
//
// Optional feature: define CHECKER_AUTO_WATCHDOG_EN to build the per-run
// watchdog counter and its timeout exit. Without it, RUN waits indefinitely
// and the `watchdog` parameter has no effect.
//
// Parameters:
//   mode      mode code this block answers to
//   watchdog  max cycles per MPU run (watchdog build only)
// Ports:
//   sys_clk, sys_rst       clock, synchronous active-high reset
//   mode_mode/mode_start   selected mode and start pulse from ctlif
//   mode_addr              [31:0] wait period, [47:32] run count (0 = infinite)
//   mode_end/irq/data      result outputs; exactly 0 outside DONE
//   mode_ack               IRQ acknowledge
//   mpu_en/mpu_rst         MPU enable and one-cycle reset request
//   mpu_error              MPU fault
//   mpu_user_irq/data      MPU run finished, with its result word
module checker_auto #(
  parameter logic [1:0]  mode     = 2'd2,
  parameter logic [31:0] watchdog = 32'd1_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [1:0]  mode_mode,
  input  logic        mode_start,
  input  logic [63:0] mode_addr,
  output logic        mode_end,
  output logic [63:0] mode_data,
  output logic        mode_irq,
  input  logic        mode_ack,
  output logic        mpu_en,
  output logic        mpu_rst,
  input  logic        mpu_error,
  input  logic [63:0] mpu_user_data,
  input  logic        mpu_user_irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  logic [31:0] period;
  logic [15:0] run_cnt;
  logic [15:0] run_idx;
  logic [63:0] baseline;
  logic [31:0] wait_cnt;

  logic [15:0] run_nx;
  logic        mismatch;
  logic        last_run;
  logic        wdog_hit;

  // Run index after the current run completes. It wraps at 16 bits.
  assign run_nx   = run_idx + 16'd1;

  // Run 0 defines the baseline, so it can never mismatch.
  assign mismatch = (run_idx != 16'd0) && (mpu_user_data != baseline);
  assign last_run = (run_cnt != 16'd0) && (run_nx == run_cnt);

`ifdef CHECKER_AUTO_WATCHDOG_EN
  logic [31:0] wdog_cnt;
  assign wdog_hit = (wdog_cnt == watchdog);

  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      wdog_cnt <= '0;
    else if (state == S_RST)
      wdog_cnt <= '0;
    else if (state == S_RUN && !wdog_hit)
      wdog_cnt <= wdog_cnt + 32'd1;
  end

  logic unused_cfg;
  assign unused_cfg = ^mode_addr[63:48];
`else
  assign wdog_hit = 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^{watchdog, mode_addr[63:48]};
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      period    <= '0;
      run_cnt   <= '0;
      run_idx   <= '0;
      baseline  <= '0;
      wait_cnt  <= '0;
      mode_end  <= 1'b0;
      mode_irq  <= 1'b0;
      mode_data <= '0;
      mpu_en    <= 1'b0;
      mpu_rst   <= 1'b0;
    end else begin
      // mpu_rst is a single-cycle pulse. It is re-armed only on entry to RST.
      mpu_rst <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mode_start && mode_mode == mode) begin
            period  <= mode_addr[31:0];
            run_cnt <= mode_addr[47:32];
            run_idx <= '0;
            mpu_rst <= 1'b1;
            state   <= S_RST;
          end
        end

        S_RST: begin
          mpu_en <= 1'b1;
          state  <= S_RUN;
        end

        S_RUN: begin
          if (mpu_error) begin
            mpu_en    <= 1'b0;
            mode_end  <= 1'b1;
            mode_irq  <= 1'b1;
            mode_data <= {32'hFFFF_FFFF, 16'h0, run_idx};
            state     <= S_DONE;
          end else if (mpu_user_irq) begin
            mpu_en <= 1'b0;
            if (run_idx == 16'd0)
              baseline <= mpu_user_data;
            if (mismatch) begin
              mode_end  <= 1'b1;
              mode_irq  <= 1'b1;
              mode_data <= mpu_user_data;
              state     <= S_DONE;
            end else begin
              run_idx <= run_nx;
              if (last_run) begin
                // On this path the result equals the baseline. That holds
                // even on run 0, where the baseline is still being written,
                // so the live data word is reported.
                mode_end  <= 1'b1;
                mode_irq  <= 1'b1;
                mode_data <= mpu_user_data;
                state     <= S_DONE;
              end else begin
                wait_cnt <= period;
                state    <= S_WAIT;
              end
            end
          end else if (wdog_hit) begin
            mpu_en    <= 1'b0;
            mode_end  <= 1'b1;
            mode_irq  <= 1'b1;
            mode_data <= {32'hFFFF_FFFE, 16'h0, run_idx};
            state     <= S_DONE;
          end
        end

        // WAIT lasts P+1 cycles. Together with RST, this gives a P+2-cycle
        // gap between enables.
        S_WAIT: begin
          if (wait_cnt == 32'd0) begin
            mpu_rst <= 1'b1;
            state   <= S_RST;
          end else begin
            wait_cnt <= wait_cnt - 32'd1;
          end
        end

        S_DONE: begin
          if (mode_ack) begin
            mode_end  <= 1'b0;
            mode_irq  <= 1'b0;
            mode_data <= '0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_checker_auto.sv
module tb_checker_auto;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [1:0]  mode_mode;
  logic        mode_start;
  logic [63:0] mode_addr;
  logic        mode_end;
  logic [63:0] mode_data;
  logic        mode_irq;
  logic        mode_ack;
  logic        mpu_en;
  logic        mpu_rst;
  logic        mpu_error;
  logic [63:0] mpu_user_data;
  logic        mpu_user_irq;

  checker_auto #(.mode(2'd2), .watchdog(32'd100)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .mode_mode(mode_mode), .mode_start(mode_start), .mode_addr(mode_addr),
    .mode_end(mode_end), .mode_data(mode_data), .mode_irq(mode_irq),
    .mode_ack(mode_ack), .mpu_en(mpu_en), .mpu_rst(mpu_rst),
    .mpu_error(mpu_error), .mpu_user_data(mpu_user_data),
    .mpu_user_irq(mpu_user_irq)
  );

  initial forever #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Scenario description used by run_scn.
  int          sc_p, sc_n, sc_err, sc_ack;
  int          sc_dly[8];
  logic [63:0] sc_res[8];
  bit          sc_extra;
  bit          sc_use_expd;
  logic [63:0] sc_expd;

  typedef struct {
    int          p;
    int          n;
    logic [63:0] r0, r1, r2;
    int          err;
    int          dly;
    logic [63:0] exp_data;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [67:0] got, input logic [67:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    mode_start = 0; mode_mode = 2'd2; mode_addr = '0; mode_ack = 0;
    mpu_error = 0; mpu_user_irq = 0; mpu_user_data = '0;
  endtask

  // Timeline model: run k enables at s[k]. Each run lasts dly+1 cycles,
  // followed by P+2 disabled cycles. The outcome follows the baseline rules.
  task automatic run_scn(input string tag);
    int s[8];
    int dn, done_c, last_c;
    logic [63:0] b, d;
    logic e_rst, e_en, e_done;
    b = sc_res[0]; dn = -1; d = '0;
    for (int k = 0; k < 8; k++) begin
      if (dn < 0) begin
        if (k == sc_err) begin d = {32'hFFFF_FFFF, 16'h0, 16'(k)}; dn = k; end
        else if (k > 0 && sc_res[k] != b) begin d = sc_res[k]; dn = k; end
        else if (sc_n != 0 && k + 1 == sc_n) begin d = b; dn = k; end
      end
    end
    if (dn < 0) begin dn = 7; d = '0; end
    s[0] = 2;
    for (int k = 1; k < 8; k++) s[k] = s[k-1] + sc_dly[k-1] + sc_p + 3;
    done_c = s[dn] + sc_dly[dn] + 1;
    last_c = done_c + sc_ack + 3;
    for (int c = 0; c <= last_c; c++) begin
      e_rst = 0; e_en = 0;
      for (int k = 0; k <= dn; k++) begin
        if (c == s[k] - 1) e_rst = 1;
        if (c >= s[k] && c <= s[k] + sc_dly[k]) e_en = 1;
      end
      e_done = (c >= done_c) && (c <= done_c + sc_ack);
      chk({tag, "/cyc"}, {mpu_rst, mpu_en, mode_end, mode_irq, mode_data},
          {e_rst, e_en, e_done, e_done, (e_done ? d : 64'h0)});
      if (c == done_c && sc_use_expd)
        chk({tag, "/data"}, {4'h0, mode_data}, {4'h0, sc_expd});
      mode_mode  = 2'd2;
      mode_start = (c == 0) || (sc_extra && c == s[0] + sc_dly[0] + 1);
      mode_addr  = (c == 0) ? {16'hBEEF, 16'(sc_n), 32'(sc_p)} : {16'h0, 16'd1, 32'd0};
      mpu_user_irq = 0; mpu_error = 0; mpu_user_data = {$urandom, $urandom};
      for (int k = 0; k <= dn; k++) begin
        if (c == s[k] + sc_dly[k]) begin
          mpu_user_irq  = 1;
          mpu_user_data = sc_res[k];
          if (k == sc_err) mpu_error = 1;
        end
      end
      mode_ack = (c == done_c + sc_ack) || (sc_extra && c == 2);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    logic [63:0] base;
    int bad_cyc;

    // Directed table: P, N, results, error run, delay, expected data.
    tbl[0] = '{10, 3, 64'h1234, 64'h1234, 64'h1234, -1, 0, 64'h1234};
    tbl[1] = '{0, 0, 64'hA, 64'hA, 64'hB, -1, 0, 64'hB};
    tbl[2] = '{3, 0, 64'h5, 64'h5, 64'h5, 1, 1, 64'hFFFF_FFFF_0000_0001};
    tbl[3] = '{1, 1, 64'h77, 64'h77, 64'h77, -1, 2, 64'h77};
    tbl[4] = '{2, 2, 64'h9, 64'h8, 64'h9, -1, 1, 64'h8};
    tbl[5] = '{0, 0, 64'hC, 64'hC, 64'hC, 0, 3, 64'hFFFF_FFFF_0000_0000};

    idle_inputs();
    sys_rst = 1;
    tick(); tick();
    chk("reset", {mpu_rst, mpu_en, mode_end, mode_irq, mode_data}, 68'h0);
    sys_rst = 0;
    tick();

    for (int i = 0; i < 6; i++) begin
      sc_p = tbl[i].p; sc_n = tbl[i].n; sc_err = tbl[i].err; sc_ack = 2;
      sc_res[0] = tbl[i].r0; sc_res[1] = tbl[i].r1;
      for (int k = 2; k < 8; k++) sc_res[k] = tbl[i].r2;
      for (int k = 0; k < 8; k++) sc_dly[k] = tbl[i].dly;
      sc_extra = (i == 0); sc_use_expd = 1; sc_expd = tbl[i].exp_data;
      run_scn($sformatf("tbl%0d", i));
    end

    // Wrong mode code: no response at all.
    mode_mode = 2'd1; mode_start = 1; mode_addr = {16'h0, 16'd1, 32'd0};
    tick();
    mode_start = 0;
    for (int c = 0; c < 20; c++) begin
      chk("wrong_mode", {mpu_rst, mpu_en, mode_end, mode_irq, mode_data}, 68'h0);
      tick();
    end
    idle_inputs();

    // Reset in the middle of run 1, then a fresh start must re-capture the baseline.
    mode_addr = '0; mode_start = 1;
    tick(); mode_start = 0;              // cycle 1
    tick();                              // cycle 2: RUN
    mpu_user_irq = 1; mpu_user_data = 64'h55;
    tick(); mpu_user_irq = 0;            // cycle 3: WAIT
    tick(); tick();                      // cycle 5: RUN again
    chk("rst_mid/en", {67'h0, mpu_en}, 68'h1);
    sys_rst = 1;
    tick();
    chk("rst_mid/out", {mpu_rst, mpu_en, mode_end, mode_irq, mode_data}, 68'h0);
    sys_rst = 0;
    tick();
    sc_p = 1; sc_n = 2; sc_err = -1; sc_ack = 0; sc_extra = 0;
    for (int k = 0; k < 8; k++) begin sc_res[k] = 64'h66; sc_dly[k] = 1; end
    sc_use_expd = 1; sc_expd = 64'h66;
    run_scn("rst_recap");

`ifdef CHECKER_AUTO_WATCHDOG_EN
    mode_addr = '0; mode_start = 1;
    for (int c = 0; c <= 108; c++) begin
      if (c > 0) begin
        chk("wdog", {1'b0, mpu_en, mode_end, mode_irq, mode_data},
            {1'b0, (c >= 2 && c <= 102), (c >= 103 && c <= 105), (c >= 103 && c <= 105),
             ((c >= 103 && c <= 105) ? 64'hFFFF_FFFE_0000_0000 : 64'h0)});
      end
      mode_ack = (c == 105);
      tick();
      mode_start = 0;
    end
    idle_inputs();
`else
    mode_addr = '0; mode_start = 1;
    tick(); mode_start = 0;
    bad_cyc = 0;
    for (int c = 1; c < 10000; c++) begin
      if (mode_end || (c >= 2 && !mpu_en)) bad_cyc++;
      tick();
    end
    chk("no_wdog", 68'(bad_cyc), 68'h0);
    sys_rst = 1; tick(); sys_rst = 0; tick();
`endif

    // Randomized scenarios against the timeline model.
    for (int i = 0; i < 40; i++) begin
      base = {$urandom, $urandom};
      sc_p = $urandom_range(0, 6);
      sc_n = $urandom_range(0, 4);
      sc_ack = $urandom_range(0, 3);
      sc_err = ($urandom_range(0, 9) < 2) ? $urandom_range(0, 7) : -1;
      sc_res[0] = base;
      for (int k = 1; k < 8; k++) sc_res[k] = ($urandom_range(0, 5) == 0) ? (base ^ 64'h1) : base;
      sc_res[7] = base ^ 64'h2;
      for (int k = 0; k < 8; k++) sc_dly[k] = $urandom_range(0, 4);
      sc_extra = $urandom_range(0, 1);
      sc_use_expd = 0; sc_expd = '0;
      run_scn($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
